// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants and word/address types for sram_core
//
// Purpose: default geometry of the flop-based scratch SRAM and the matching
// address/data word typedefs, imported by the interface, core and bench.
package sram_pkg;

  localparam int SRAM_DATA_SIZE_DEF  = 16;
  localparam int SRAM_DEPTH_LOG2_DEF = 5;

  typedef logic [SRAM_DEPTH_LOG2_DEF-1:0] sram_addr_t;
  typedef logic [SRAM_DATA_SIZE_DEF-1:0]  sram_word_t;

endpackage

// File: rtl/sram_if.sv
// rtl/sram_if.sv - read/write bus bundle for sram_core
//
// Purpose: groups the SRAM write port, read port and full flag.
// Signals:
//   data_wren, addr_in, data_in : write enable, write address, write data
//   data_rden, addr_out         : read enable, read address
//   data_out                    : registered read data
//   sram_full                   : write address is at the top location
// Modports: master (datapath driving the SRAM), slave (sram_core).
interface sram_if
  import sram_pkg::*;
#(
  parameter int DATA_SIZE       = SRAM_DATA_SIZE_DEF,
  parameter int SRAM_DEPTH_LOG2 = SRAM_DEPTH_LOG2_DEF
) ();

  logic                       data_rden;
  logic                       data_wren;
  logic [DATA_SIZE-1:0]       data_in;
  logic [DATA_SIZE-1:0]       data_out;
  logic [SRAM_DEPTH_LOG2-1:0] addr_in;
  logic [SRAM_DEPTH_LOG2-1:0] addr_out;
  logic                       sram_full;

  modport master (
    output data_rden, data_wren, data_in, addr_in, addr_out,
    input  data_out, sram_full
  );

  modport slave (
    input  data_rden, data_wren, data_in, addr_in, addr_out,
    output data_out, sram_full
  );

endinterface

// File: rtl/sram_core.sv
// rtl/sram_core.sv - flop-based dual-address synchronous SRAM
//
// Purpose: SRAM_DEPTH words of DATA_SIZE bits. A rising edge with data_wren
// writes data_in to addr_in; a rising edge with data_rden loads the word at
// addr_out into the data_out register (one-cycle latency, held otherwise).
// Reset (asynchronous, active-high) clears every word and data_out.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : sram_if.slave (see rtl/sram_if.sv for the signal list)
// Build option: SRAM_WRITE_THROUGH_EN - a same-cycle read and write of the
// same address forwards data_in to data_out; otherwise reads return the
// old contents (read-first).
module sram_core
  import sram_pkg::*;
#(
  parameter  int DATA_SIZE       = SRAM_DATA_SIZE_DEF,
  parameter  int SRAM_DEPTH_LOG2 = SRAM_DEPTH_LOG2_DEF,
  localparam int SRAM_DEPTH      = 2 ** SRAM_DEPTH_LOG2
) (
  input logic   clock,
  input logic   reset,
  sram_if.slave bus
);

  typedef logic [SRAM_DEPTH_LOG2-1:0] addr_t;
  typedef logic [DATA_SIZE-1:0]       word_t;

  localparam addr_t ADDR_TOP = addr_t'(SRAM_DEPTH - 1);

  word_t mem_q [SRAM_DEPTH];
  word_t mem_d [SRAM_DEPTH];
  word_t data_out_q;
  word_t data_out_d;

  always_comb begin
    mem_d = mem_q;
    if (bus.data_wren) begin
      mem_d[bus.addr_in] = bus.data_in;
    end
  end

  // Read samples mem_q (pre-write contents), which gives read-first
  // ordering on a same-address collision unless the bypass is built in.
  always_comb begin
    data_out_d = data_out_q;
    if (bus.data_rden) begin
      data_out_d = mem_q[bus.addr_out];
`ifdef SRAM_WRITE_THROUGH_EN
      if (bus.data_wren && (bus.addr_in == bus.addr_out)) begin
        data_out_d = bus.data_in;
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out  = data_out_q;
  // Pure address decode: deliberately independent of data_wren and reset.
  assign bus.sram_full = (bus.addr_in == ADDR_TOP);

endmodule

// File: tb/tb_sram_core.sv
// tb/tb_sram_core.sv - directed vector bench for sram_core
module tb_sram_core;
  import sram_pkg::*;

  typedef struct {
    logic       rst;
    logic       wren;
    logic       rden;
    sram_addr_t ain;
    sram_addr_t aout;
    sram_word_t din;
    sram_word_t exp_out;
    logic       exp_full;
  } vec_t;

  localparam int NV = 20;

  logic clock = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs [NV];
  sram_word_t exp_same;

  always #5 clock = ~clock;

  sram_if #(.DATA_SIZE(SRAM_DATA_SIZE_DEF), .SRAM_DEPTH_LOG2(SRAM_DEPTH_LOG2_DEF)) bus ();

  sram_core #(.DATA_SIZE(SRAM_DATA_SIZE_DEF), .SRAM_DEPTH_LOG2(SRAM_DEPTH_LOG2_DEF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input sram_word_t act, input sram_word_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wren, input logic rden, input sram_addr_t ain,
                       input sram_addr_t aout, input sram_word_t din);
    bus.data_wren = wren;
    bus.data_rden = rden;
    bus.addr_in   = ain;
    bus.addr_out  = aout;
    bus.data_in   = din;
  endtask

  initial begin
`ifdef SRAM_WRITE_THROUGH_EN
    exp_same = 16'h55AA;
`else
    exp_same = 16'h1234;
`endif
    //          rst   wren  rden  ain    aout   din       exp_out   full
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  16'd32,   16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  16'h0000, 16'd32,   1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd7,  16'h0000, 16'd32,   1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'd30, 5'd0,  16'd100,  16'd32,   1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 5'd31, 5'd0,  16'd200,  16'd32,   1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'd31, 5'd0,  16'h0000, 16'd32,   1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd30, 16'h0000, 16'd100,  1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd31, 16'h0000, 16'd200,  1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 5'd5,  5'd0,  16'h1234, 16'd200,  1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 5'd5,  5'd5,  16'h55AA, exp_same, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 5'd5,  5'd5,  16'h0000, 16'h55AA, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 5'd3,  5'd30, 16'h0007, 16'd100,  1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 5'd3,  5'd3,  16'h0000, 16'h0007, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 5'd3,  5'd0,  16'h0000, 16'd32,   1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 5'd31, 5'd0,  16'h9999, 16'h0000, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd31, 16'h0000, 16'h0000, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd5,  16'h0000, 16'h0000, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 5'd1,  5'd0,  16'hA5A5, 16'h0000, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd1,  16'h0000, 16'hA5A5, 1'b0};

    // Reset held 50 cycles with active enables; nothing may get through.
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd0, 5'd0, 16'hFFFF);
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (c % 10 == 9) check($sformatf("reset_hold_%0d", c), bus.data_out, 16'h0000);
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 16'h0000);

    for (int i = 0; i < NV; i++) begin
      reset = vecs[i].rst;
      drive(vecs[i].wren, vecs[i].rden, vecs[i].ain, vecs[i].aout, vecs[i].din);
      @(posedge clock);
      @(negedge clock);
      check($sformatf("vec%0d_data_out", i), bus.data_out, vecs[i].exp_out);
      check($sformatf("vec%0d_sram_full", i), {15'b0, bus.sram_full}, {15'b0, vecs[i].exp_full});
    end

    // Rebuild state, then hit reset mid-burst between clock edges.
    reset = 1'b0;
    drive(1'b1, 1'b0, 5'd30, 5'd0, 16'd100);
    @(negedge clock);
    drive(1'b1, 1'b1, 5'd31, 5'd30, 16'd200);
    @(negedge clock);
    drive(1'b1, 1'b1, 5'd31, 5'd31, 16'hBEEF);
    @(posedge clock);
    #2;
    check("burst_pre_reset", bus.data_out, 16'd200);
    reset = 1'b1;
    #1;
    check("reset_async_data_out", bus.data_out, 16'h0000);
    check("reset_sram_full", {15'b0, bus.sram_full}, 16'h0001);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 1'b1, 5'd0, 5'd0, 16'h0000);
    @(posedge clock);
    @(negedge clock);
    check("post_reset_rd0", bus.data_out, 16'h0000);
    drive(1'b0, 1'b1, 5'd0, 5'd30, 16'h0000);
    @(posedge clock);
    @(negedge clock);
    check("post_reset_rd30", bus.data_out, 16'h0000);
    drive(1'b0, 1'b1, 5'd0, 5'd31, 16'h0000);
    @(posedge clock);
    @(negedge clock);
    check("post_reset_rd31", bus.data_out, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
